// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and constants for the scoreboarded register file.
package reg_file_sb_pkg;

   localparam int unsigned XLEN_DEF         = 32;
   localparam int unsigned NUM_REGS_DEF     = 32;
   localparam int unsigned AW_DEF           = $clog2(NUM_REGS_DEF);
   localparam int unsigned NUM_RD_PORTS_DEF = 2;
   localparam int unsigned PC_INC_DEF       = 4;
   localparam int unsigned RESET_PC_DEF     = 0;
   localparam int unsigned X0_IDX           = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for RAW stall detection, with per-read-port lookup.
// REGFILE_WR_BYPASS_EN: a same-cycle completing write clears the reported busy bit.
module reg_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter int unsigned NUM_REGS     = NUM_REGS_DEF,
   parameter int unsigned NUM_RD_PORTS = NUM_RD_PORTS_DEF,
   parameter int unsigned AW           = $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       halt,
   input  logic                       issue_en,
   input  logic [AW-1:0]              issue_addr,
   input  logic                       wr_en,
   input  logic [AW-1:0]              wr_addr,
   input  logic [NUM_RD_PORTS*AW-1:0] rd_addr,
   output logic [NUM_RD_PORTS-1:0]    rd_busy
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // Issue is applied after the clear so a new producer supersedes a completing one.
   always_comb begin
      busy_d = busy_q;
      if (!halt) begin
         if (wr_en) busy_d[wr_addr] = 1'b0;
         if (issue_en) busy_d[issue_addr] = 1'b1;
      end
      busy_d[X0_IDX] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      logic [AW-1:0] ra;
      assign ra = rd_addr[p*AW +: AW];
`ifdef REGFILE_WR_BYPASS_EN
      logic fwd;
      assign fwd = !halt && wr_en && (wr_addr == ra) && (ra != '0)
                   && !(issue_en && (issue_addr == ra));
      assign rd_busy[p] = busy_q[ra] & ~fwd;
`else
      assign rd_busy[p] = busy_q[ra];
`endif
   end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with dedicated PC and RAW busy scoreboard.
// REGFILE_WR_BYPASS_EN: forward the writeback value to matching read ports same cycle.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int unsigned XLEN         = XLEN_DEF,
   parameter int unsigned NUM_REGS     = NUM_REGS_DEF,
   parameter int unsigned NUM_RD_PORTS = NUM_RD_PORTS_DEF,
   parameter logic [XLEN-1:0] PC_INC   = XLEN'(PC_INC_DEF),
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
   parameter int unsigned AW           = $clog2(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         halt,
   input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr,
   output logic [NUM_RD_PORTS*XLEN-1:0] rd_data,
   output logic [NUM_RD_PORTS-1:0]      rd_busy,
   input  logic                         wr_en,
   input  logic [AW-1:0]                wr_addr,
   input  logic [XLEN-1:0]              wr_data,
   input  logic                         issue_en,
   input  logic [AW-1:0]                issue_addr,
   input  logic                         pc_load,
   input  logic [XLEN-1:0]              pc_load_val,
   input  logic                         pc_freeze,
   output logic [XLEN-1:0]              pc_out
);

   localparam logic [AW-1:0] X0_ADDR = AW'(X0_IDX);

   logic [XLEN-1:0] regs_q [NUM_REGS];
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic            wr_we;

   assign wr_we = !halt && wr_en && (wr_addr != X0_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      end else if (wr_we) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      pc_d = pc_q;
      if (!halt) begin
         if (pc_load) pc_d = pc_load_val;
         else if (!pc_freeze) pc_d = pc_q + PC_INC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_out = pc_q;

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rd_addr[p*AW +: AW];
`ifdef REGFILE_WR_BYPASS_EN
      assign rd_data[p*XLEN +: XLEN] = (wr_we && (wr_addr == ra)) ? wr_data : regs_q[ra];
`else
      assign rd_data[p*XLEN +: XLEN] = regs_q[ra];
`endif
   end

   reg_scoreboard #(
      .NUM_REGS     (NUM_REGS),
      .NUM_RD_PORTS (NUM_RD_PORTS),
      .AW           (AW)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .halt       (halt),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .rd_addr    (rd_addr),
      .rd_busy    (rd_busy)
   );

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core register file: configurable XLEN, register count and read-port count.
- PC is a dedicated register, not an array slot. It has a parametrised increment and reset vector.
- Adds a per-register busy scoreboard so the control unit can stall on RAW hazards.
- Sits between decode/control (read addresses, issue) and writeback (write port, PC load) in the pipeline.

Parameters:
XLEN, 32, data and PC width in bits
NUM_REGS, 32, architectural registers incl. x0; power of 2, >=2
NUM_RD_PORTS, 2, independent combinational read ports, 1..4
PC_INC, 4, value added to PC per advancing cycle
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
halt  in  1  freeze every register, PC and busy bit
rd_addr  in  NUM_RD_PORTS*AW  packed read addresses, port p at [p*AW +: AW], AW=$clog2(NUM_REGS)
rd_data  out  NUM_RD_PORTS*XLEN  packed read data, port p at [p*XLEN +: XLEN]
rd_busy  out  NUM_RD_PORTS  busy bit of the register addressed by each read port
wr_en  in  1  writeback enable
wr_addr  in  AW  writeback destination
wr_data  in  XLEN  writeback data
issue_en  in  1  instruction with destination issued; mark destination busy
issue_addr  in  AW  destination of issued instruction
pc_load  in  1  load PC from pc_load_val (jump/branch taken)
pc_load_val  in  XLEN  new PC value
pc_freeze  in  1  hold PC (stall)
pc_out  out  XLEN  current PC

Behaviour:
- Reset (rst=1, async): all registers 0, all busy bits 0, PC=RESET_PC. Outputs follow immediately: rd_data=0, rd_busy=0, pc_out=RESET_PC. Deassertion is taken at the next clk edge.
- halt=1: no state changes, regardless of wr_en/issue_en/pc_load. Reads remain live.
- Read: rd_data[p]=reg[rd_addr[p]], combinational, zero latency.
- x0 always reads 0 and is never written. busy[0] is never set, so rd_busy for address 0 is always 0.
- Write: if wr_en and wr_addr!=0, reg[wr_addr]<=wr_data at the edge. Visible on rd_data the cycle after, unless the macro below is defined.
- PC priority when halt=0: pc_load > pc_freeze > increment.
  - pc_load: PC<=pc_load_val.
  - pc_freeze: PC holds.
  - else: PC<=PC+PC_INC, modulo 2^XLEN (wraps, e.g. 0xFFFFFFFC+4=0).
- Scoreboard, per register r!=0, when halt=0:
  - set if issue_en and issue_addr==r;
  - clear if wr_en and wr_addr==r;
  - both in the same cycle: set wins (new producer supersedes completing one).
  - Issue of a register that is already busy: stays busy, no error.
  - Write to a register that is not busy: data written, busy stays 0.
- rd_busy[p]=busy[rd_addr[p]], combinational from state (no same-cycle forwarding of issue/write).
- Reset asserted mid-operation discards pending writes, loads and busy state; there is no recovery of in-flight state.

Optional Feature:
- Macro REGFILE_WR_BYPASS_EN.
- Defined:
  - If wr_en and wr_addr==rd_addr[p] and wr_addr!=0, then rd_data[p]=wr_data in the same cycle.
  - rd_busy[p] is also forced to 0 in that case, unless issue_en targets the same register that cycle.
  - Bypass is suppressed while halt=1.
- Undefined: reads return stored contents only; a write is visible the next cycle.

Decomposition:
- Shared package: XLEN default, NUM_REGS default, derived AW, RESET_PC default, PC_INC default. Also the localparam for x0 index (0).
- One natural sub-module: reg_scoreboard. It holds the NUM_REGS busy vector, set/clear priority, halt gating and the per-port busy lookup. It is instantiated once inside reg_file_sb.
- The data array and PC stay in the parent.

Test Plan:
- Reset then release, halt=0, no controls, 3 cycles -> pc_out 0,4,8,12. rd_data=0 and rd_busy=0 on all ports; asserting rst mid-count -> pc_out=0 immediately.
- wr_en, wr_addr=5, wr_data=0xDEADBEEF; then rd_addr[0]=5 -> 0xDEADBEEF next cycle. A write to x0 with 0x1234 -> reads 0.
- issue_en addr=7 -> rd_busy=1 for port reading 7. Next cycle wr_en addr=7 and issue_en addr=7 together -> still busy. Then wr_en addr=7 alone -> busy=0.
- pc_load=1 val=0x100 with pc_freeze=1 -> PC=0x100. Then pc_freeze=1 -> holds 0x100. PC=0xFFFFFFFC with increment -> 0.
- halt=1 with wr_en addr=3, issue_en addr=4, pc_load=1 -> reg3, busy4 and PC all unchanged after 2 cycles. Deassert halt -> normal operation resumes.
- With REGFILE_WR_BYPASS_EN: wr_en addr=9 data=0xA5 and rd_addr[1]=9 in the same cycle -> rd_data[1]=0xA5 combinationally. Without the macro -> old value that cycle, 0xA5 next.
